// File: rtl/apb_pkg.sv
// Shared APB types and helpers.
// Used by the completer and its register file.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } apb_cpl_state_t;

  // Word aligned and inside the register bank.
  function automatic logic addr_is_legal(
    input logic [APB_ADDR_W-1:0] addr,
    input int unsigned           num_regs
  );
    return (addr[1:0] == 2'b00) &&
           ((addr >> 2) < num_regs);
  endfunction

endpackage

// File: rtl/apb_if.sv
// APB link bundle shared by the master
// and the completer.
interface apb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport apb_master (
    output psel,
    output penable,
    output paddr,
    output pwrite,
    output pwdata,
    input  prdata,
    input  pready,
    input  pslverr
  );

  modport apb_slave (
    input  psel,
    input  penable,
    input  paddr,
    input  pwrite,
    input  pwdata,
    output prdata,
    output pready,
    output pslverr
  );

endinterface

// File: rtl/apb_regfile.sv
// Word register bank: one write port,
// one combinational read port.
module apb_regfile #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_completer.sv
// APB completer: register bank behind a
// setup/access FSM with programmable waits.
module apb_completer
  import apb_pkg::*;
#(
  parameter int ADDR_W   = APB_ADDR_W,
  parameter int DATA_W   = APB_DATA_W,
  parameter int NUM_REGS = 16,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic              pwrite_i,
  input  logic [DATA_W-1:0] pwdata_i,
  output logic [DATA_W-1:0] prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  input  logic [WAIT_W-1:0] wait_cycles_i
);

  localparam int IDX_W =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  apb_cpl_state_t state_q, state_d;

  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              write_q, write_n;
  logic [DATA_W-1:0] wdata_q;
  logic              pready_q;
  logic              pslverr_q;
  logic [DATA_W-1:0] prdata_q;

  logic              setup, access;
  logic              latch, legal_n;
  logic              enter_resp, we;
  logic [DATA_W-1:0] rdata;

  assign setup  = psel_i & ~penable_i;
  assign access = psel_i & penable_i;
  assign latch  = (state_q == IDLE) & setup;

  // Outputs are registered, so the decode looks
  // through to the bus while values are latched.
  assign addr_n  = (state_q == IDLE) ? paddr_i  : addr_q;
  assign write_n = (state_q == IDLE) ? pwrite_i : write_q;
  assign legal_n =
    addr_is_legal(APB_ADDR_W'(addr_n), NUM_REGS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          if (wait_cycles_i == '0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = wait_cycles_i - WAIT_W'(1);
          end
        end
      end
      WAIT: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else if (access) begin
          if (cnt_q == '0) begin
            state_d = RESP;
          end else begin
            cnt_d = cnt_q - WAIT_W'(1);
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign enter_resp =
    (state_d == RESP) & (state_q != RESP);
  assign we =
    (state_q == RESP) & write_q & legal_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (latch) begin
        addr_q  <= paddr_i;
        write_q <= pwrite_i;
        wdata_q <= pwdata_i;
      end
      pready_q  <= enter_resp;
      pslverr_q <= enter_resp & ~legal_n;
      prdata_q  <=
        (enter_resp & ~write_n & legal_n) ?
        rdata : '0;
    end
  end

  apb_regfile #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .widx    (addr_q[IDX_W+1:2]),
    .wdata   (wdata_q),
    .ridx    (addr_n[IDX_W+1:2]),
    .rdata   (rdata)
  );

  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign prdata_o  = prdata_q;

endmodule
